encoder_interface_am: RTL



---
 rtl/encoder_interface_am.sv | 110 +++++++++++
 1 files changed

// File: rtl/encoder_interface_am.sv
// Registered TX block selector: forwards CGMII blocks, replaces gaps with alignment-marker
// idle blocks for latched AM requests, or with error blocks when no request explains the gap.
module encoder_interface_am #(
    parameter int LEN_TX_CTRL = 8,
    parameter int LEN_TX_DATA = 64,
    parameter int AM_TIMEOUT  = 4,
    parameter int NB_ERR_CNT  = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_valid,
    input  logic                   i_am_req,
    input  logic [LEN_TX_DATA-1:0] i_tx_data,
    input  logic [LEN_TX_CTRL-1:0] i_tx_ctrl,
    input  logic                   i_err_clr,
    output logic [LEN_TX_DATA-1:0] o_tx_data,
    output logic [LEN_TX_CTRL-1:0] o_tx_ctrl,
    output logic                   o_am_flag,
    output logic                   o_am_pending,
    output logic                   o_am_miss,
    output logic [NB_ERR_CNT-1:0]  o_err_count
);

    localparam int CW = $clog2(AM_TIMEOUT + 1);
    localparam logic [CW-1:0]          TIMEOUT_CNT = CW'(AM_TIMEOUT);
    localparam logic [LEN_TX_DATA-1:0] IDLE_BLOCK  = {LEN_TX_CTRL{8'h07}};
    localparam logic [LEN_TX_DATA-1:0] ERROR_BLOCK = {LEN_TX_CTRL{8'hFE}};
    localparam logic [LEN_TX_CTRL-1:0] CTRL_ALL    = {LEN_TX_CTRL{1'b1}};
    localparam logic [NB_ERR_CNT-1:0]  ERR_MAX     = {NB_ERR_CNT{1'b1}};

    typedef enum logic {NO_AM, AM_WAIT} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            wait_q, wait_d;
    logic [CW-1:0]            waited;
    logic                     am_active;
    logic                     err_inc;
    logic [LEN_TX_DATA-1:0]   data_d;
    logic [LEN_TX_CTRL-1:0]   ctrl_d;
    logic                     flag_d, miss_d;
    logic [NB_ERR_CNT-1:0]    err_d;

    assign am_active    = (state_q == AM_WAIT) || i_am_req;
    assign waited       = wait_q + CW'(1);
    assign o_am_pending = (state_q == AM_WAIT);

    // NOTE: every signal gets a default before the decision tree so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        data_d  = i_tx_data;
        ctrl_d  = i_tx_ctrl;
        flag_d  = 1'b0;
        miss_d  = 1'b0;
        err_inc = 1'b0;
        if (am_active && !i_valid) begin
            data_d  = IDLE_BLOCK;
            ctrl_d  = CTRL_ALL;
            flag_d  = 1'b1;
            state_d = NO_AM;
            wait_d  = '0;
        end else if (am_active) begin
            // A new request arriving during a pending wait never restarts the counter.
            if (waited >= TIMEOUT_CNT) begin
                miss_d  = 1'b1;
                state_d = NO_AM;
                wait_d  = '0;
            end else begin
                state_d = AM_WAIT;
                wait_d  = waited;
            end
        end else if (!i_valid) begin
            data_d  = ERROR_BLOCK;
            ctrl_d  = CTRL_ALL;
            err_inc = 1'b1;
        end
    end

    // A clear coinciding with a gap keeps that gap's event.
    always_comb begin
        err_d = o_err_count;
        if (i_err_clr)
            err_d = err_inc ? NB_ERR_CNT'(1) : '0;
        else if (err_inc && o_err_count != ERR_MAX)
            err_d = o_err_count + NB_ERR_CNT'(1);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= NO_AM;
            wait_q      <= '0;
            o_tx_data   <= IDLE_BLOCK;
            o_tx_ctrl   <= CTRL_ALL;
            o_am_flag   <= 1'b0;
            o_am_miss   <= 1'b0;
            o_err_count <= '0;
        end else if (i_enable) begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            o_tx_data   <= data_d;
            o_tx_ctrl   <= ctrl_d;
            o_am_flag   <= flag_d;
            o_am_miss   <= miss_d;
            o_err_count <= err_d;
        end
    end

endmodule
